// File: rtl/cmd_cfg_pkg.sv
// Shared types and constants for the command decoder / config register file.
package cmd_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESP_WAIT = 3'd1,
        DUMP_LOAD = 3'd2,
        DUMP_SEND = 3'd3,
        DUMP_WAIT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_DUMP = 2'b10,
        OP_RSVD = 2'b11
    } opcode_t;

    localparam logic [7:0] ACK          = 8'hA5;
    localparam logic [7:0] NAK          = 8'hEE;
    localparam int         CAP_DONE_BIT = 5;

endpackage

// File: rtl/cmd_cfg_multi_if.sv
// Host command/response and capture-RAM readout signals of the command block.
// Handshakes: cmd is held with cmd_rdy until the one-cycle clr_cmd_rdy; resp is
// stable from the send_resp pulse until the one-cycle resp_sent; rdata is valid
// the cycle after a strt_rd or rd_nxt pulse and holds until the next one.
interface cmd_cfg_multi_if #(
    parameter int NUM_CH = 5
);
    logic [15:0]         cmd;
    logic                cmd_rdy;
    logic                clr_cmd_rdy;
    logic [7:0]          resp;
    logic                send_resp;
    logic                resp_sent;
    logic                strt_rd;
    logic                rd_nxt;
    logic                rd_done;
    logic [NUM_CH*8-1:0] rdata;

    modport master (
        output cmd, cmd_rdy, resp_sent, rd_done, rdata,
        input  clr_cmd_rdy, resp, send_resp, strt_rd, rd_nxt
    );

    modport slave (
        input  cmd, cmd_rdy, resp_sent, rd_done, rdata,
        output clr_cmd_rdy, resp, send_resp, strt_rd, rd_nxt
    );
endinterface

// File: rtl/cmd_cfg_regbank.sv
// NUM_REGS x 8 configuration register bank with one write port, a combinational
// read mux and the capture_done flag merge.
module cmd_cfg_regbank
    import cmd_cfg_pkg::*;
#(
    parameter int NUM_REGS = 17,
    parameter int TRIG_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [5:0]            wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  set_capture_done,
    input  logic [5:0]            rd_addr,
    output logic [7:0]            rd_data,
    output logic [NUM_REGS*8-1:0] cfg_regs
);
    logic [7:0] regs [NUM_REGS];

    // The flag set is the later assignment so it wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && (wr_addr == 6'(i))) regs[i] <= wr_data;
            end
            if (set_capture_done) regs[TRIG_REG][CAP_DONE_BIT] <= 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 6'(i)) rd_data = regs[i];
        end
    end

    always_comb begin
        cfg_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) cfg_regs[i*8 +: 8] = regs[i];
    end
endmodule

// File: rtl/cmd_cfg_multi.sv
// Host command decoder, channel-dump engine and config register file.
// Define CMD_CFG_MULTI_DUMP_ALL_EN to make dump channel 0 stream every channel per sample.
module cmd_cfg_multi
    import cmd_cfg_pkg::*;
#(
    parameter int NUM_CH   = 5,
    parameter int NUM_REGS = 17,
    parameter int TRIG_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    cmd_cfg_multi_if.slave        bus,
    input  logic                  set_capture_done,
    output logic [NUM_REGS*8-1:0] cfg_regs,
    output state_t                state
);
    opcode_t    op;
    logic [5:0] addr;
    logic [2:0] ch_code;
    logic [2:0] dump_ch;
    logic [2:0] ch;
    logic       addr_ok;
    logic       dump_ok;
    logic       wr_en;
    logic       last_ch;
    logic [7:0] rd_data;
    logic [7:0] ch_byte;
    logic [7:0] reply;

    assign op      = opcode_t'(bus.cmd[15:14]);
    assign addr    = bus.cmd[13:8];
    assign ch_code = bus.cmd[10:8];
    assign addr_ok = {1'b0, addr} < 7'(NUM_REGS);
    assign wr_en   = (state == IDLE) && bus.cmd_rdy && (op == OP_WR) && addr_ok;

`ifdef CMD_CFG_MULTI_DUMP_ALL_EN
    logic all_mode;
    assign dump_ok = {1'b0, ch_code} <= 4'(NUM_CH);
    assign dump_ch = (ch_code == 3'd0) ? 3'd0 : ch_code - 3'd1;
    assign last_ch = !all_mode || (ch == 3'(NUM_CH - 1));
`else
    assign dump_ok = (ch_code != 3'd0) && ({1'b0, ch_code} <= 4'(NUM_CH));
    assign dump_ch = ch_code - 3'd1;
    assign last_ch = 1'b1;
`endif

    cmd_cfg_regbank #(
        .NUM_REGS(NUM_REGS),
        .TRIG_REG(TRIG_REG)
    ) u_regbank (
        .clk              (clk),
        .rst              (rst),
        .wr_en            (wr_en),
        .wr_addr          (addr),
        .wr_data          (bus.cmd[7:0]),
        .set_capture_done (set_capture_done),
        .rd_addr          (addr),
        .rd_data          (rd_data),
        .cfg_regs         (cfg_regs)
    );

    always_comb begin
        reply = NAK;
        if (addr_ok && (op == OP_RD))      reply = rd_data;
        else if (addr_ok && (op == OP_WR)) reply = ACK;
    end

    always_comb begin
        ch_byte = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == 3'(c)) ch_byte = bus.rdata[c*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ch              <= '0;
            bus.resp        <= '0;
            bus.clr_cmd_rdy <= 1'b0;
            bus.send_resp   <= 1'b0;
            bus.strt_rd     <= 1'b0;
            bus.rd_nxt      <= 1'b0;
`ifdef CMD_CFG_MULTI_DUMP_ALL_EN
            all_mode        <= 1'b0;
`endif
        end else begin
            bus.clr_cmd_rdy <= 1'b0;
            bus.send_resp   <= 1'b0;
            bus.strt_rd     <= 1'b0;
            bus.rd_nxt      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_rdy) begin
                        bus.clr_cmd_rdy <= 1'b1;
                        if ((op == OP_DUMP) && dump_ok) begin
                            ch          <= dump_ch;
                            bus.strt_rd <= 1'b1;
                            state       <= DUMP_LOAD;
`ifdef CMD_CFG_MULTI_DUMP_ALL_EN
                            all_mode    <= (ch_code == 3'd0);
`endif
                        end else begin
                            bus.resp      <= reply;
                            bus.send_resp <= 1'b1;
                            state         <= RESP_WAIT;
                        end
                    end
                end
                RESP_WAIT: if (bus.resp_sent) state <= IDLE;
                // RAM output lands one cycle after strt_rd/rd_nxt.
                DUMP_LOAD: state <= DUMP_SEND;
                DUMP_SEND: begin
                    bus.resp      <= ch_byte;
                    bus.send_resp <= 1'b1;
                    state         <= DUMP_WAIT;
                end
                DUMP_WAIT: begin
                    if (bus.resp_sent) begin
                        if (!last_ch) begin
                            ch    <= ch + 3'd1;
                            state <= DUMP_SEND;
                        end else if (bus.rd_done) begin
                            state <= IDLE;
                        end else begin
                            bus.rd_nxt <= 1'b1;
                            state      <= DUMP_LOAD;
`ifdef CMD_CFG_MULTI_DUMP_ALL_EN
                            if (all_mode) ch <= '0;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_cfg_multi.sv
// Directed bench for cmd_cfg_multi: register access, NAK paths, channel dumps,
// capture_done merge and reset during a dump.
module tb_cmd_cfg_multi;
    import cmd_cfg_pkg::*;

    localparam int NUM_CH   = 5;
    localparam int NUM_REGS = 17;
    localparam int TRIG_REG = 0;

    logic                  clk;
    logic                  rst;
    logic                  set_capture_done;
    logic [NUM_REGS*8-1:0] cfg_regs;
    logic [NUM_REGS*8-1:0] exp_cfg;
    state_t                state;

    cmd_cfg_multi_if #(.NUM_CH(NUM_CH)) bus_if ();

    cmd_cfg_multi #(
        .NUM_CH   (NUM_CH),
        .NUM_REGS (NUM_REGS),
        .TRIG_REG (TRIG_REG)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus_if.slave),
        .set_capture_done (set_capture_done),
        .cfg_regs         (cfg_regs),
        .state            (state)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         ram_idx = 0;
    int         last_idx = 0;
    bit         resp_hold = 0;
    bit         resp_busy = 0;
    int         n_strt = 0;
    int         n_nxt = 0;
    int         n_send = 0;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // Capture RAM model: channel k sample i reads k*16+i.
    always @(posedge clk) begin
        if (bus_if.strt_rd)     ram_idx <= 0;
        else if (bus_if.rd_nxt) ram_idx <= ram_idx + 1;
    end

    always_comb begin
        bus_if.rdata = '0;
        for (int k = 0; k < NUM_CH; k++) bus_if.rdata[k*8 +: 8] = 8'(k * 16 + ram_idx);
    end
    assign bus_if.rd_done = (ram_idx == last_idx);

    always @(negedge clk) begin
        if (bus_if.strt_rd)   n_strt++;
        if (bus_if.rd_nxt)    n_nxt++;
        if (bus_if.send_resp) n_send++;
    end

    // UART responder: records each byte, acknowledges two cycles later.
    initial begin
        bus_if.resp_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.send_resp) begin
                got_q.push_back(bus_if.resp);
                resp_busy = 1;
                repeat (2) @(negedge clk);
                if (!resp_hold) begin
                    bus_if.resp_sent = 1'b1;
                    @(negedge clk);
                    bus_if.resp_sent = 1'b0;
                end
                resp_busy = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [15:0] c, input logic cap);
        int n = 0;
        @(negedge clk);
        bus_if.cmd       = c;
        bus_if.cmd_rdy   = 1'b1;
        set_capture_done = cap;
        do begin
            @(negedge clk);
            set_capture_done = 1'b0;
            n++;
        end while (!bus_if.clr_cmd_rdy && n < 50);
        check("clr_cmd_rdy", bus_if.clr_cmd_rdy, 1);
        bus_if.cmd_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((state != IDLE || resp_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", (state == IDLE) && !resp_busy, 1);
    endtask

    task automatic compare_resps(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic run_cmd(input logic [15:0] c, input logic [7:0] exp, input string tag);
        issue(c, 1'b0);
        wait_idle();
        exp_q.push_back(exp);
        compare_resps(tag);
    endtask

    initial begin
        rst              = 1'b1;
        set_capture_done = 1'b0;
        bus_if.cmd       = '0;
        bus_if.cmd_rdy   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", state, IDLE);
        check("rst_resp", bus_if.resp, 8'h00);
        check("rst_send_resp", bus_if.send_resp, 0);
        check("rst_clr_cmd_rdy", bus_if.clr_cmd_rdy, 0);
        check("rst_strt_rd", bus_if.strt_rd, 0);
        check("rst_rd_nxt", bus_if.rd_nxt, 0);
        check("rst_cfg_regs", cfg_regs, '0);
        rst = 1'b0;

        // Write 0x01 everywhere; the bank reflects the write by the clr_cmd_rdy cycle.
        exp_cfg = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            issue({OP_WR, 6'(i), 8'h01}, 1'b0);
            check("wr_cfg_byte", cfg_regs[i*8 +: 8], 8'h01);
            wait_idle();
            exp_q.push_back(ACK);
            compare_resps("wr_ack");
            exp_cfg[i*8 +: 8] = 8'h01;
        end
        for (int i = 0; i < NUM_REGS; i++) run_cmd({OP_RD, 6'(i), 8'h00}, 8'h01, "rd_data");
        check("cfg_after_wr", cfg_regs, exp_cfg);

        run_cmd({OP_WR, 6'h3F, 8'h55}, NAK, "nak_wr_addr");
        run_cmd({OP_RD, 6'd20, 8'h00}, NAK, "nak_rd_addr");
        run_cmd({OP_RSVD, 6'd0, 8'h77}, NAK, "nak_rsvd");
        check("cfg_after_nak", cfg_regs, exp_cfg);

        // Dump channel 3 over four samples.
        last_idx = 3;
        n_strt   = 0;
        n_nxt    = 0;
        issue({OP_DUMP, 6'd3, 8'h00}, 1'b0);
        wait_idle();
        for (int s = 0; s < 4; s++) exp_q.push_back(8'(2 * 16 + s));
        compare_resps("dump_ch3");
        check("dump_ch3_strt", n_strt, 1);
        check("dump_ch3_nxt", n_nxt, 3);

        run_cmd({OP_DUMP, 6'd6, 8'h00}, NAK, "nak_dump_ch6");

`ifdef CMD_CFG_MULTI_DUMP_ALL_EN
        last_idx = 1;
        n_strt   = 0;
        n_nxt    = 0;
        issue({OP_DUMP, 6'd0, 8'h00}, 1'b0);
        wait_idle();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < NUM_CH; k++) exp_q.push_back(8'(k * 16 + s));
        compare_resps("dump_all");
        check("dump_all_strt", n_strt, 1);
        check("dump_all_nxt", n_nxt, 1);
`else
        run_cmd({OP_DUMP, 6'd0, 8'h00}, NAK, "nak_dump_ch0");
`endif

        // capture_done in the same cycle as a write to TRIG_REG.
        issue({OP_WR, 6'(TRIG_REG), 8'h01}, 1'b1);
        wait_idle();
        exp_q.push_back(ACK);
        compare_resps("cap_wr_ack");
        check("cap_cfg_byte", cfg_regs[TRIG_REG*8 +: 8], 8'h21);
        run_cmd({OP_RD, 6'(TRIG_REG), 8'h00}, 8'h21, "cap_rd");

        // Reset while waiting for the first dump byte to be sent.
        resp_hold = 1;
        last_idx  = 3;
        issue({OP_DUMP, 6'd2, 8'h00}, 1'b0);
        for (int n = 0; n < 50 && state != DUMP_WAIT; n++) @(negedge clk);
        check("reach_dump_wait", state, DUMP_WAIT);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_state", state, IDLE);
        check("mid_rst_send_resp", bus_if.send_resp, 0);
        check("mid_rst_strt_rd", bus_if.strt_rd, 0);
        check("mid_rst_rd_nxt", bus_if.rd_nxt, 0);
        check("mid_rst_resp", bus_if.resp, 8'h00);
        check("mid_rst_cfg", cfg_regs, '0);
        rst    = 1'b0;
        n_send = 0;
        repeat (8) @(negedge clk);
        check("post_rst_no_send", n_send, 0);
        check("post_rst_state", state, IDLE);
        resp_hold = 0;
        got_q.delete();

        run_cmd({OP_RD, 6'(TRIG_REG), 8'h00}, 8'h00, "post_rst_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmd_cfg_multi.md
Name: cmd_cfg_multi

Overview:
Parametrised command decoder and configuration register file for the logic-analyzer front end. It takes 16-bit host commands from the UART wrapper, reads and writes an NUM_REGS x 8 register bank, and returns ack, nak or read data. It also runs a channel-dump engine that streams captured samples for any of NUM_CH channels back through the response path. It is the generalised successor of the fixed 5-channel, 17-register command/config block and sits between the UART wrapper and the capture RAM/trigger logic.

Parameters:
NUM_CH, 5, number of capture channels (1..7)
NUM_REGS, 17, number of 8-bit config registers (1..64)
TRIG_REG, 0, register index whose bit 5 is the capture_done flag

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cmd  input  16  host command: [15:14] opcode, [13:8] address or channel, [7:0] data
cmd_rdy  input  1  cmd valid; held until clr_cmd_rdy
clr_cmd_rdy  output  1  one-cycle pulse; cmd consumed
resp  output  8  response byte; stable while send_resp/awaiting resp_sent
send_resp  output  1  one-cycle pulse; launch resp
resp_sent  input  1  one-cycle pulse from UART; byte transmitted
set_capture_done  input  1  sets regs[TRIG_REG][5]
strt_rd  output  1  one-cycle pulse; start RAM readout at dump begin
rd_nxt  output  1  one-cycle pulse; advance RAM read pointer
rd_done  input  1  level; current sample is the last
rdata  input  NUM_CH*8  per-channel sample bytes, channel c at [c*8+7:c*8]; valid 1 cycle after strt_rd/rd_nxt
cfg_regs  output  NUM_REGS*8  flattened register bank, reg i at [i*8+7:i*8]

Behaviour:
- Encoding: opcodes are 00 read, 01 write, 10 dump, 11 reserved.
- Reset (sync, rst=1 at posedge): all regs 0, state IDLE, resp=0, and all pulses 0. Reset mid-dump aborts immediately; no further send_resp.
- Registered outputs; FSM states IDLE, RESP_WAIT, DUMP_LOAD, DUMP_SEND, DUMP_WAIT.
- IDLE, cmd_rdy=1: decode. Next cycle clr_cmd_rdy=1 plus the action below.
  - read, addr<NUM_REGS: resp=regs[addr], send_resp=1, go to RESP_WAIT.
  - write, addr<NUM_REGS: regs[addr]<=cmd[7:0], resp=0xA5, send_resp=1, go to RESP_WAIT.
  - read/write with addr>=NUM_REGS, opcode 11, or dump channel cmd[10:8] outside 1..NUM_CH: resp=0xEE, send_resp=1, go to RESP_WAIT. Register bank unchanged.
  - dump, valid channel: latch ch=cmd[10:8]-1, strt_rd=1, no send_resp, go to DUMP_LOAD.
- RESP_WAIT: hold resp; on resp_sent go to IDLE.
- DUMP_LOAD: single wait cycle for RAM latency, then go to DUMP_SEND.
- DUMP_SEND: resp=rdata[ch], send_resp=1, go to DUMP_WAIT.
- DUMP_WAIT: on resp_sent, if rd_done=1 go to IDLE; else rd_nxt=1 and go to DUMP_LOAD.
- Per-sample cadence: rd_nxt → 1 cycle → send_resp.
- cmd_rdy outside IDLE is ignored and left pending; it is served on return to IDLE.
- set_capture_done in the same cycle as a write to TRIG_REG: written value applied, then bit 5 forced to 1 (set wins).
- Read of TRIG_REG returns the live value including bit 5.
- Write latency: cfg_regs reflects a write 1 cycle after decode.

Optional Feature:
Macro CMD_CFG_MULTI_DUMP_ALL_EN.
- Enabled: dump channel code 0 is legal. Each sample step sends channels 1..NUM_CH in order (NUM_CH send_resp/resp_sent pairs) before rd_nxt. Completion is on the last channel's resp_sent with rd_done=1.
- Disabled: channel 0 returns 0xEE like any invalid channel.

Decomposition:
- Package cmd_cfg_pkg holds:
  - state_t enum {IDLE, RESP_WAIT, DUMP_LOAD, DUMP_SEND, DUMP_WAIT}
  - opcode enum {OP_RD=2'b00, OP_WR=2'b01, OP_DUMP=2'b10, OP_RSVD=2'b11}
  - localparams ACK=8'hA5, NAK=8'hEE, CAP_DONE_BIT=5
- One natural sub-module, cmd_cfg_regbank: the register array, write port, set_capture_done merge, read mux.

Test Plan:
- Reset, then write 0x01 to each reg 0..NUM_REGS-1 → each response 0xA5. Read back each → resp 0x01 (reg TRIG_REG as written), cfg_regs matches.
- Write to addr 0x3F (NUM_REGS=17), read addr 20, and opcode 11 → resp 0xEE each time; cfg_regs unchanged.
- Dump ch 3 with rdata CH3 byte = sample index, rd_done on 4th sample → strt_rd once, rd_nxt x3, resp sequence 0,1,2,3, back to IDLE. Dump ch 0 and ch 6 (NUM_CH=5) → 0xEE.
- set_capture_done pulse in the same cycle as write 0x01 to TRIG_REG → reg reads 0x21.
- Assert rst during DUMP_WAIT → next cycle state IDLE, send_resp/strt_rd/rd_nxt 0, all regs 0.
- With CMD_CFG_MULTI_DUMP_ALL_EN and NUM_CH=3, dump ch 0 over 2 samples → 6 responses in channel order, rd_nxt once.
